pipe_skid_reg: RTL
==================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (>=1).
REQ-002 Parameter NOP_PAYLOAD, default all-zero, payload presented when the stage holds no valid beat.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  discards all held beats.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  stage accepts a beat this cycle; driven directly from a flop.
REQ-009 out_valid  output  1  downstream beat present.
REQ-010 out_data  output  WIDTH  downstream payload; driven directly from a flop.
REQ-011 out_ready  input  1  downstream accepts a beat.
REQ-012 occupancy  output  2  beats held: 0, 1 or 2.

Function
REQ-013 Two storage entries: main (drives out_data) and skid (overflow); controller states EMPTY, ONE, TWO.
REQ-014 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 out_valid = 1 in ONE and TWO, 0 in EMPTY; occupancy = 0/1/2 for EMPTY/ONE/TWO.
REQ-016 in_ready = 1 in EMPTY and ONE, 0 in TWO; it does not depend combinationally on out_ready.
REQ-017 EMPTY, in_fire: main <= in_data, go to ONE. EMPTY, no in_fire: stay; main holds NOP_PAYLOAD.
REQ-018 ONE, in_fire & out_fire: main <= in_data, stay ONE.
REQ-019 ONE, in_fire only: skid <= in_data, go to TWO.
REQ-020 ONE, out_fire only: main <= NOP_PAYLOAD, go to EMPTY.
REQ-021 TWO, out_fire: main <= skid, skid <= NOP_PAYLOAD, go to ONE. TWO, no out_fire: hold everything.
REQ-022 Data order is strictly FIFO; no beat is duplicated or dropped except by flush or rst.
REQ-023 Latency: a beat accepted at edge N appears on out_data/out_valid after edge N when the stage was EMPTY, or after the edge of the first out_fire ahead of it otherwise.
REQ-024 Sustained throughput is one beat per cycle while in_valid = out_ready = 1.
REQ-025 flush = 1 at an edge: main and skid <= NOP_PAYLOAD, state <= EMPTY, in_ready <= 1; a beat offered in that cycle is discarded.
REQ-026 flush has priority over every handshake; out_fire in a flush cycle still counts as consumed downstream.
REQ-027 out_data equals NOP_PAYLOAD whenever out_valid = 0 (bubble insertion).
REQ-028 out_data stays stable while out_valid = 1 and out_ready = 0.

Reset
REQ-029 rst = 1 at an edge: state EMPTY, main and skid <= NOP_PAYLOAD, out_valid 0, in_ready 1, occupancy 0.
REQ-030 rst has priority over flush and all handshakes, including mid-transfer in state TWO.
REQ-031 The first cycle after rst deasserts accepts a beat (in_ready = 1).

Structure
REQ-032 Shared package pipe_pkg holds the state enum (EMPTY, ONE, TWO) and the default NOP payload constant.
REQ-033 One sub-module, pipe_skid_ctrl, holds the state machine and produces in_ready, out_valid, occupancy and the main/skid load selects; pipe_skid_reg owns the data flops.
REQ-034 No latches and no combinational path from out_ready to in_ready.

Verification
REQ-035 Directed scenarios (WIDTH = 32, NOP_PAYLOAD = 0):
- Single beat: EMPTY, drive in_data = 0x11 with out_ready = 1 -> next cycle out_valid = 1, out_data = 0x11, then EMPTY with out_data = 0.
- Back-pressure: send 0xA1, 0xA2 with out_ready = 0 -> occupancy 2, in_ready 0. Raise out_ready -> 0xA1 then 0xA2 on consecutive cycles, in_ready back to 1 one cycle after the first out_fire.
- Streaming: 8 beats 0x0-0x7 with in_valid = out_ready = 1 -> output one per cycle, in order, no gaps.
- Flush in TWO: hold 0xB1, 0xB2 and offer 0xB3 with flush = 1 -> next cycle out_valid 0, out_data 0, occupancy 0. 0xB3 never appears at the output.
- Simultaneous in ONE: hold 0xC1, offer 0xC2 with out_ready = 1 -> 0xC1 consumed, out_data 0xC2, occupancy stays 1.
- Reset mid-operation: rst = 1 while occupancy = 2 and flush = 1 -> all outputs at reset values next cycle, and the first beat after release passes normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding, load selects and default bubble payload for the skid stage
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_IN,
        MAIN_SKID,
        MAIN_NOP
    } main_sel_t;

    typedef enum logic [1:0] {
        SKID_HOLD,
        SKID_IN,
        SKID_NOP
    } skid_sel_t;

    // Fill bit for the default bubble payload; replicated to any payload width.
    localparam logic NOP_FILL = 1'b0;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// pipe_skid_ctrl: occupancy state machine and main/skid load selects for the skid register
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] occupancy,
    output main_sel_t  main_sel,
    output skid_sel_t  skid_sel
);

    state_t state_q, state_d;
    logic   in_ready_q, in_ready_d;
    logic   in_fire, out_fire;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign occupancy = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;

    // Next state and data-load selects; flush overrides every handshake.
    always_comb begin
        state_d  = state_q;
        main_sel = MAIN_HOLD;
        skid_sel = SKID_HOLD;
        in_fire  = in_valid & in_ready_q;
        out_fire = out_valid & out_ready;
        if (flush) begin
            state_d  = EMPTY;
            main_sel = MAIN_NOP;
            skid_sel = SKID_NOP;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_sel = MAIN_IN;
                        state_d  = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_sel = MAIN_IN;
                    end else if (in_fire) begin
                        skid_sel = SKID_IN;
                        state_d  = TWO;
                    end else if (out_fire) begin
                        main_sel = MAIN_NOP;
                        state_d  = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_sel = MAIN_SKID;
                        skid_sel = SKID_NOP;
                        state_d  = ONE;
                    end
                end
                default: begin
                    main_sel = MAIN_NOP;
                    skid_sel = SKID_NOP;
                    state_d  = EMPTY;
                end
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    // State register; in_ready is registered so it never depends on out_ready combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid pipeline register with flush and bubble (NOP) insertion
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] NOP_PAYLOAD = {WIDTH{NOP_FILL}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [1:0]       occupancy
);

    main_sel_t        main_sel;
    skid_sel_t        skid_sel;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    pipe_skid_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .occupancy (occupancy),
        .main_sel  (main_sel),
        .skid_sel  (skid_sel)
    );

    assign out_data = main_q;

    // Entry next values chosen by the controller's load selects.
    always_comb begin
        main_d = (main_sel == MAIN_IN)   ? in_data     :
                 (main_sel == MAIN_SKID) ? skid_q      :
                 (main_sel == MAIN_NOP)  ? NOP_PAYLOAD : main_q;
        skid_d = (skid_sel == SKID_IN)   ? in_data     :
                 (skid_sel == SKID_NOP)  ? NOP_PAYLOAD : skid_q;
    end

    // Payload flops; empty entries always hold the bubble payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= NOP_PAYLOAD;
            skid_q <= NOP_PAYLOAD;
        end else begin
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

endmodule
